bids22_host_seq: RTL and testbench

//  Command-side initiator for the bids22 auction controller. Accepts one auction-config request,

---
 rtl/bids22_host_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bids22_host_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bids22_host_seq.sv
// bids22 host-side command sequencer: load config, LOCK, timed round, collect result, UNLOCK.
// Optional feature macro: BIDS22_HOST_RETRY_EN (BADKEY backoff and UNLOCK retry).
package bids22defs;
  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    LOCK         = 4'd1,
    UNLOCK       = 4'd2,
    LOADX        = 4'd3,
    LOADY        = 4'd4,
    LOADZ        = 4'd5,
    SETMASK      = 4'd6,
    SETTIMER     = 4'd7,
    SETBIDCHARGE = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    NOERROR           = 3'd0,
    BADKEY            = 3'd1,
    ALREADYLOCKED     = 3'd2,
    INVALID_OP        = 3'd3,
    INSUFFICIENTFUNDS = 3'd4,
    DUPLICATEBIDS     = 3'd5,
    ROUNDACTIVE       = 3'd6
  } err_t;
endpackage

module bids22_host_seq #(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int ROUNDW     = 8,
  parameter int WAIT_LIMIT = 64,
  parameter int MAX_RETRY  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATAWIDTH-1:0]   cfg_key,
  input  logic [DATAWIDTH-1:0]   cfg_x,
  input  logic [DATAWIDTH-1:0]   cfg_y,
  input  logic [DATAWIDTH-1:0]   cfg_z,
  input  logic [NUMBIDDERS-1:0]  cfg_mask,
  input  logic [DATAWIDTH-1:0]   cfg_timer,
  input  logic [DATAWIDTH-1:0]   cfg_bidcharge,
  input  logic [ROUNDW-1:0]      cfg_round_len,
  output bids22defs::opcode_t    C_op,
  output logic [DATAWIDTH-1:0]   C_data,
  output logic                   C_start,
  input  logic                   ready,
  input  bids22defs::err_t       err,
  input  logic                   roundOver,
  input  logic [DATAWIDTH-1:0]   maxBid,
  output logic                   done,
  output logic [DATAWIDTH-1:0]   result_maxbid,
  output bids22defs::err_t       result_err,
  output logic                   timeout
);
  import bids22defs::*;

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WLAST = WCW'(WAIT_LIMIT - 1);
  localparam logic [WCW-1:0] WMAX  = {WCW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOCK, S_LGAP, S_ROUND, S_WAIT, S_UNLOCK, S_UCHK,
`ifdef BIDS22_HOST_RETRY_EN
    S_BACKOFF,
`endif
    S_FAIL, S_DONE
  } state_t;

  typedef struct packed {
    logic [DATAWIDTH-1:0]  key;
    logic [DATAWIDTH-1:0]  x;
    logic [DATAWIDTH-1:0]  y;
    logic [DATAWIDTH-1:0]  z;
    logic [NUMBIDDERS-1:0] mask;
    logic [DATAWIDTH-1:0]  timer;
    logic [DATAWIDTH-1:0]  charge;
    logic [ROUNDW-1:0]     round_len;
  } cfg_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  cfg_t                 cfg_q, cfg_d;
  logic [ROUNDW-1:0]    rcnt_q, rcnt_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [DATAWIDTH-1:0] maxbid_q, maxbid_d;
  err_t                 rerr_q, rerr_d;
  logic                 timeout_q, timeout_d;

`ifdef BIDS22_HOST_RETRY_EN
  localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RCW-1:0]       retry_q, retry_d;
  logic [DATAWIDTH:0]   bcnt_q, bcnt_d;
`endif

  opcode_t              load_op;
  logic [DATAWIDTH-1:0] load_data;

  // Load command table indexed by idx_q; outputs stay put while idx_q is held.
  always_comb begin
    load_op   = NO_OP;
    load_data = '0;
    case (idx_q)
      3'd0: begin load_op = LOADX;        load_data = cfg_q.x;                  end
      3'd1: begin load_op = LOADY;        load_data = cfg_q.y;                  end
      3'd2: begin load_op = LOADZ;        load_data = cfg_q.z;                  end
      3'd3: begin load_op = SETMASK;      load_data = DATAWIDTH'(cfg_q.mask);   end
      3'd4: begin load_op = SETTIMER;     load_data = cfg_q.timer;              end
      3'd5: begin load_op = SETBIDCHARGE; load_data = cfg_q.charge;             end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cfg_d     = cfg_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    maxbid_d  = maxbid_q;
    rerr_d    = rerr_q;
    timeout_d = timeout_q;
`ifdef BIDS22_HOST_RETRY_EN
    retry_d   = retry_q;
    bcnt_d    = bcnt_q;
`endif
    C_op      = NO_OP;
    C_data    = '0;
    C_start   = 1'b0;
    done      = 1'b0;
    req_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cfg_d = '{key: cfg_key, x: cfg_x, y: cfg_y, z: cfg_z, mask: cfg_mask,
                    timer: cfg_timer, charge: cfg_bidcharge, round_len: cfg_round_len};
          idx_d     = '0;
          maxbid_d  = '0;
          rerr_d    = NOERROR;
          timeout_d = 1'b0;
`ifdef BIDS22_HOST_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        C_op   = load_op;
        C_data = load_data;
        if (err != NOERROR) begin
          rerr_d  = err;
          state_d = S_FAIL;
        end else if (ready) begin
          if (idx_q == 3'd5) state_d = S_LOCK;
          else               idx_d   = idx_q + 3'd1;
        end
      end

      S_LOCK: begin
        C_op   = LOCK;
        C_data = cfg_q.key;
        if (err != NOERROR) begin
          rerr_d  = err;
          state_d = S_FAIL;
        end else if (ready) begin
          state_d = S_LGAP;
        end
      end

      // Quiet cycle after LOCK; a late LOCK error still aborts here.
      S_LGAP: begin
        if (err != NOERROR) begin
          rerr_d  = err;
          state_d = S_FAIL;
        end else begin
          rcnt_d  = (cfg_q.round_len == '0) ? ROUNDW'(1) : cfg_q.round_len;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        C_start  = 1'b1;
        maxbid_d = maxBid;
        if (err == DUPLICATEBIDS) rerr_d = DUPLICATEBIDS;
        if (rcnt_q <= ROUNDW'(1)) begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          rcnt_d  = rcnt_q - ROUNDW'(1);
        end
      end

      S_WAIT: begin
        if (err == DUPLICATEBIDS) rerr_d = DUPLICATEBIDS;
        if (roundOver) begin
          maxbid_d = maxBid;
          state_d  = S_UNLOCK;
        end else if (wcnt_q == WLAST) begin
          timeout_d = 1'b1;
          state_d   = S_UNLOCK;
        end else if (wcnt_q != WMAX) begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      S_UNLOCK: begin
        C_op   = UNLOCK;
        C_data = cfg_q.key;
        if (ready) state_d = S_UCHK;
      end

      S_UCHK: begin
        if (err == BADKEY) begin
`ifdef BIDS22_HOST_RETRY_EN
          if (retry_q < RCW'(MAX_RETRY)) begin
            retry_d = retry_q + RCW'(1);
            bcnt_d  = {1'b0, cfg_q.timer} + (DATAWIDTH+1)'(1);
            state_d = S_BACKOFF;
          end else begin
            rerr_d  = BADKEY;
            state_d = S_FAIL;
          end
`else
          rerr_d  = BADKEY;
          state_d = S_FAIL;
`endif
        end else begin
          state_d = S_DONE;
        end
      end

`ifdef BIDS22_HOST_RETRY_EN
      // Down-count from timer+1 to 0 gives timer+2 backoff cycles.
      S_BACKOFF: begin
        if (bcnt_q == '0) state_d = S_UNLOCK;
        else              bcnt_d  = bcnt_q - (DATAWIDTH+1)'(1);
      end
`endif

      S_FAIL: state_d = S_DONE;

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cfg_q     <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      maxbid_q  <= '0;
      rerr_q    <= NOERROR;
      timeout_q <= 1'b0;
`ifdef BIDS22_HOST_RETRY_EN
      retry_q   <= '0;
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_q     <= cfg_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      maxbid_q  <= maxbid_d;
      rerr_q    <= rerr_d;
      timeout_q <= timeout_d;
`ifdef BIDS22_HOST_RETRY_EN
      retry_q   <= retry_d;
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign result_maxbid = maxbid_q;
  assign result_err    = rerr_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_bids22_host_seq.sv
// Scoreboard bench for bids22_host_seq: a behavioural auction model drives the inputs,
// expected commands/results are queued at stimulus time and checked by a separate monitor.
module tb_bids22_host_seq;
  import bids22defs::*;

  localparam int DW = 32;
  localparam int NB = 3;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] cfg_key, cfg_x, cfg_y, cfg_z, cfg_timer, cfg_bidcharge;
  logic [NB-1:0] cfg_mask;
  logic [RW-1:0] cfg_round_len;
  opcode_t       C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          ready;
  err_t          err;
  logic          roundOver;
  logic [DW-1:0] maxBid;
  logic          done;
  logic [DW-1:0] result_maxbid;
  err_t          result_err;
  logic          timeout;

  always #5 clk = ~clk;

  bids22_host_seq dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .cfg_key(cfg_key), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z), .cfg_mask(cfg_mask),
    .cfg_timer(cfg_timer), .cfg_bidcharge(cfg_bidcharge), .cfg_round_len(cfg_round_len),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
    .roundOver(roundOver), .maxBid(maxBid), .done(done), .result_maxbid(result_maxbid),
    .result_err(result_err), .timeout(timeout)
  );

  typedef struct {
    logic [DW-1:0] key, x, y, z;
    logic [NB-1:0] mask;
    logic [DW-1:0] timer, charge;
    logic [RW-1:0] len;
  } bcfg_t;

  typedef struct {
    opcode_t       op;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] maxbid;
    err_t          rerr;
    logic          tmo;
    int            n_start;
    int            lock_span;
    int            loady;
    int            n_unl;
    int            ul_gap;
  } res_t;

  cmd_t cmd_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;

  // model knobs, set by stimulus
  int            stall_left = 0;
  opcode_t       stall_op   = NO_OP;
  bit            inj_en     = 1'b0;
  opcode_t       inj_op     = NO_OP;
  err_t          inj_err    = NOERROR;
  bit            dup_en     = 1'b0;
  int            ro_delay   = 0;
  logic [DW-1:0] ro_bid     = '0;
  logic [DW-1:0] round_bid  = '0;
  int            badkey_left = 0;
  logic [DW-1:0] exp_y      = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Auction model: evaluates 2 time units after each rising edge.
  initial begin
    int  ro_cnt = 0;
    bit  prev_start = 1'b0;
    bit  prev_unl = 1'b0;
    ready = 1'b1; err = NOERROR; roundOver = 1'b0; maxBid = '0;
    forever begin
      @(posedge clk); #2;
      if (!reset_n) begin
        ro_cnt = 0; prev_start = 1'b0; prev_unl = 1'b0;
        ready = 1'b1; err = NOERROR; roundOver = 1'b0; maxBid = '0;
      end else begin
        ready = 1'b1;
        if (C_op == stall_op && stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end
        err = NOERROR;
        if (inj_en && C_op == inj_op) err = inj_err;
        if (dup_en && C_start) err = DUPLICATEBIDS;
        if (prev_unl && badkey_left > 0) begin
          err = BADKEY;
          badkey_left--;
        end
        roundOver = 1'b0;
        maxBid = C_start ? round_bid : '0;
        if (ro_cnt > 0) begin
          ro_cnt--;
          if (ro_cnt == 0) begin
            roundOver = 1'b1;
            maxBid = ro_bid;
          end
        end
        if (prev_start && !C_start && ro_delay > 0) ro_cnt = ro_delay;
        prev_start = C_start;
        prev_unl = (C_op == UNLOCK) && ready;
      end
    end
  end

  // Monitor: samples on falling edges.
  int cyc = 0, n_start, loady, n_unl, lx_cyc, lock_cyc, ul1_cyc, ul_gap;

  task automatic clr_stats();
    n_start = 0; loady = 0; n_unl = 0; lx_cyc = -1; lock_cyc = -1; ul1_cyc = -1; ul_gap = 0;
  endtask

  initial begin
    cmd_t e;
    res_t r;
    clr_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        clr_stats();
      end else begin
        if (C_start) n_start++;
        if (C_op == LOADY && C_data == exp_y) loady++;
        if (C_op != NO_OP && ready) begin
          if (cmd_q.size() == 0) begin
            fail_now($sformatf("cmd_unexpected op=%0d data=%0d", C_op, C_data));
          end else begin
            e = cmd_q.pop_front();
            chk("cmd_op", C_op, e.op);
            chk("cmd_data", C_data, e.data);
          end
          if (C_op == LOADX) lx_cyc = cyc;
          if (C_op == LOCK) lock_cyc = cyc;
          if (C_op == UNLOCK) begin
            n_unl++;
            if (n_unl == 1) ul1_cyc = cyc;
            else if (n_unl == 2) ul_gap = cyc - ul1_cyc;
          end
        end
        if (done) begin
          if (res_q.size() == 0) begin
            fail_now("done_unexpected");
          end else begin
            r = res_q.pop_front();
            chk("result_maxbid", result_maxbid, r.maxbid);
            chk("result_err", result_err, r.rerr);
            chk("timeout", timeout, r.tmo);
            chk("start_cycles", n_start, r.n_start);
            chk("lock_span", (lock_cyc < 0) ? -1 : lock_cyc - lx_cyc, r.lock_span);
            chk("loady_cycles", loady, r.loady);
            chk("unlock_count", n_unl, r.n_unl);
            chk("unlock_gap", ul_gap, r.ul_gap);
            chk("cmds_left", cmd_q.size(), 0);
          end
          clr_stats();
        end
      end
    end
  end

  task automatic push_cmds(input bcfg_t c, input int n, input int n_unl_exp);
    cmd_t l[7];
    l[0] = '{LOADX, c.x};
    l[1] = '{LOADY, c.y};
    l[2] = '{LOADZ, c.z};
    l[3] = '{SETMASK, 32'(c.mask)};
    l[4] = '{SETTIMER, c.timer};
    l[5] = '{SETBIDCHARGE, c.charge};
    l[6] = '{LOCK, c.key};
    for (int i = 0; i < n; i++) cmd_q.push_back(l[i]);
    for (int i = 0; i < n_unl_exp; i++) cmd_q.push_back('{UNLOCK, c.key});
  endtask

  task automatic send(input bcfg_t c, input int hold_extra);
    bit got;
    @(posedge clk); #1;
    req_valid = 1'b1;
    cfg_key = c.key; cfg_x = c.x; cfg_y = c.y; cfg_z = c.z; cfg_mask = c.mask;
    cfg_timer = c.timer; cfg_bidcharge = c.charge; cfg_round_len = c.len;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) fail_now("req_ready_wait");
    @(posedge clk); #1;
    if (hold_extra > 0) begin
      cfg_x = c.x + 32'd1000;
      chk("req_ready_busy", req_ready, 0);
      repeat (hold_extra) @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) fail_now({"done_wait_", nm});
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string p);
    chk({p, "_C_op"}, C_op, NO_OP);
    chk({p, "_C_data"}, C_data, 0);
    chk({p, "_C_start"}, C_start, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_result_maxbid"}, result_maxbid, 0);
    chk({p, "_result_err"}, result_err, NOERROR);
    chk({p, "_timeout"}, timeout, 0);
    chk({p, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bcfg_t c;
    bit    got;
    reset_n = 1'b0; req_valid = 1'b0;
    cfg_key = '0; cfg_x = '0; cfg_y = '0; cfg_z = '0; cfg_mask = '0;
    cfg_timer = '0; cfg_bidcharge = '0; cfg_round_len = '0;
    repeat (2) @(posedge clk); #1;
    check_idle("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    c = '{key: 32'hA5A5_0001, x: 100, y: 80, z: 60, mask: 3'b111, timer: 4, charge: 1, len: 5};
    exp_y = 80;

    // basic run, roundOver 2 cycles after C_start falls, extra req_valid ignored
    ro_delay = 2; ro_bid = 42; round_bid = 9;
    push_cmds(c, 7, 1);
    res_q.push_back('{32'd42, NOERROR, 1'b0, 5, 6, 1, 1, 0});
    send(c, 3);
    wait_done("basic");

    // 3-cycle stall on LOADY
    stall_op = LOADY; stall_left = 3;
    push_cmds(c, 7, 1);
    res_q.push_back('{32'd42, NOERROR, 1'b0, 5, 9, 4, 1, 0});
    send(c, 0);
    wait_done("stall");
    stall_op = NO_OP;

    // roundOver never comes
    ro_delay = 0; round_bid = 17;
    push_cmds(c, 7, 1);
    res_q.push_back('{32'd17, NOERROR, 1'b1, 5, 6, 1, 1, 0});
    send(c, 0);
    wait_done("timeout");

    // INVALID_OP on SETMASK
    ro_delay = 2; round_bid = 9;
    inj_en = 1'b1; inj_op = SETMASK; inj_err = INVALID_OP;
    push_cmds(c, 4, 0);
    res_q.push_back('{32'd0, INVALID_OP, 1'b0, 0, -1, 1, 0, 0});
    send(c, 0);
    wait_done("invalid_op");
    inj_en = 1'b0;

    // single BADKEY answer to UNLOCK
    badkey_left = 1;
`ifdef BIDS22_HOST_RETRY_EN
    push_cmds(c, 7, 2);
    res_q.push_back('{32'd42, NOERROR, 1'b0, 5, 6, 1, 2, 8});
`else
    push_cmds(c, 7, 1);
    res_q.push_back('{32'd42, BADKEY, 1'b0, 5, 6, 1, 1, 0});
`endif
    send(c, 0);
    wait_done("badkey");
    badkey_left = 0;

    // async reset in the middle of ROUND
    push_cmds(c, 7, 1);
    send(c, 0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (C_start) got = 1'b1;
    end
    if (!got) fail_now("c_start_wait");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle("midreset");
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_req_ready", req_ready, 1);

    // recovery: round_len 0 runs one cycle; DUPLICATEBIDS recorded without abort
    c.len = 0;
    dup_en = 1'b1; ro_bid = 55;
    push_cmds(c, 7, 1);
    res_q.push_back('{32'd55, DUPLICATEBIDS, 1'b0, 1, 6, 1, 1, 0});
    send(c, 0);
    wait_done("len0_dup");
    dup_en = 1'b0;

    chk("results_left", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
